// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: assembles framed command packets from UART receiver bytes.
// Frame format: HEADER, CMD, LEN, LEN payload bytes, XOR checksum over CMD/LEN/payload.
// A validated packet is held on a valid/ready interface until accepted; malformed
// frames are dropped and reported on one-cycle error pulses.
// Optional feature: define UART_PKT_TIMEOUT_EN to build the inter-byte timeout
// counter; without it err_timeout is tied low and partial frames wait indefinitely.
module uart_pkt_parser #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 104166
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [7:0]           pkt_cmd,
  output logic [4:0]           pkt_len,
  output logic [MAX_LEN*8-1:0] pkt_payload,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_ovr,
  output logic                 err_timeout
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // Reject parameter values the 5-bit length field and the counter cannot represent.
  if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_pkt_parser: MAX_LEN must be 1..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_rx_done_d;
  logic                 w_byte_stb;

  logic [7:0]           r_cmd;
  logic [4:0]           r_len;
  logic [4:0]           r_idx;
  logic [7:0]           r_csum;
  logic [MAX_LEN*8-1:0] r_payload;

  logic                 r_err_chk;
  logic                 r_err_len;
  logic                 r_err_ovr;
  logic                 r_err_timeout;

  // Control strobes from the FSM to the datapath.
  logic                 w_clr_pay;
  logic                 w_ld_cmd;
  logic                 w_ld_len;
  logic                 w_ld_pay;
  logic                 w_err_chk;
  logic                 w_err_len;
  logic                 w_err_ovr;
  logic                 w_timeout;

  // Edge-detect rx_done so a level held for several cycles yields exactly one byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_done_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value of its inputs regardless of statement order.
      r_rx_done_d <= rx_done;
    end
  end

  assign w_byte_stb = rx_done & ~r_rx_done_d;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_counting;

  // Timeout only runs while a frame is partially received.
  assign w_counting = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CHK);

  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout  = w_counting && !w_byte_stb &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter: cleared by every byte and outside the frame body.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (!w_counting || w_byte_stb || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_clr_pay   = 1'b0;
    w_ld_cmd    = 1'b0;
    w_ld_len    = 1'b0;
    w_ld_pay    = 1'b0;
    w_err_chk   = 1'b0;
    w_err_len   = 1'b0;
    w_err_ovr   = 1'b0;

    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_byte_stb && (rx_data == HEADER)) begin
            w_clr_pay   = 1'b1;
            w_state_nxt = S_CMD;
          end
        end
        S_CMD: begin
          if (w_byte_stb) begin
            w_ld_cmd    = 1'b1;
            w_state_nxt = S_LEN;
          end
        end
        S_LEN: begin
          if (w_byte_stb) begin
            if (rx_data > MAX_LEN_B) begin
              w_err_len   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ld_len    = 1'b1;
              w_state_nxt = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_byte_stb) begin
            w_ld_pay = 1'b1;
            if (r_idx == (r_len - 5'd1)) begin
              w_state_nxt = S_CHK;
            end
          end
        end
        S_CHK: begin
          if (w_byte_stb) begin
            if (rx_data == r_csum) begin
              w_state_nxt = S_HOLD;
            end else begin
              w_err_chk   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          // Any byte here is lost, even when the packet is accepted on the same edge.
          w_err_ovr = w_byte_stb;
          if (pkt_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Packet fields, running checksum and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload buffer is reset along with the rest of the datapath so
      // the packet outputs read zero after reset rather than stale data.
      r_payload     <= '0;
      r_cmd         <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_csum        <= '0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_ovr     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_clr_pay) begin
        r_payload <= '0;
      end
      if (w_ld_cmd) begin
        r_cmd  <= rx_data;
        r_csum <= rx_data;
      end
      if (w_ld_len) begin
        r_len  <= rx_data[4:0];
        r_csum <= r_csum ^ rx_data;
        r_idx  <= '0;
      end
      if (w_ld_pay) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (r_idx == 5'(i)) begin
            r_payload[8*i +: 8] <= rx_data;
          end
        end
        r_csum <= r_csum ^ rx_data;
        r_idx  <= r_idx + 5'd1;
      end
      r_err_chk     <= w_err_chk;
      r_err_len     <= w_err_len;
      r_err_ovr     <= w_err_ovr;
      r_err_timeout <= w_timeout;
    end
  end

  assign pkt_valid   = (r_state == S_HOLD);
  assign pkt_cmd     = r_cmd;
  assign pkt_len     = r_len;
  assign pkt_payload = r_payload;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_ovr     = r_err_ovr;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed testbench for uart_pkt_parser (MAX_LEN=8, TIMEOUT_CYC=100).
// Timeout scenario is built when UART_PKT_TIMEOUT_EN is defined; otherwise the
// bench checks that a partial frame waits indefinitely.
module tb_uart_pkt_parser;

  localparam int MAX_LEN     = 8;
  localparam int TIMEOUT_CYC = 100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_done = 1'b0;
  logic                 pkt_ready = 1'b0;
  logic                 pkt_valid;
  logic [7:0]           pkt_cmd;
  logic [4:0]           pkt_len;
  logic [MAX_LEN*8-1:0] pkt_payload;
  logic                 err_chk;
  logic                 err_len;
  logic                 err_ovr;
  logic                 err_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err_chk = 0;
  int n_err_len = 0;
  int n_err_ovr = 0;
  int n_err_to  = 0;

  uart_pkt_parser #(
    .HEADER     (8'hAA),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_cmd    (pkt_cmd),
    .pkt_len    (pkt_len),
    .pkt_payload(pkt_payload),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_ovr    (err_ovr),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Count error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_chk === 1'b1) n_err_chk++;
    if (err_len === 1'b1) n_err_len++;
    if (err_ovr === 1'b1) n_err_ovr++;
    if (err_timeout === 1'b1) n_err_to++;
  end

  // One byte: rx_done high for one cycle, then two idle cycles.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pulse pkt_ready for one cycle.
  task automatic accept();
    @(posedge clk); #1;
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
    n_cmp++;
    if (pkt_cmd !== 8'h00 || pkt_len !== 5'd0 || pkt_payload !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_pkt: got cmd=%h len=%0d pl=%h want 0/0/0", pkt_cmd, pkt_len, pkt_payload);
    end
    n_cmp++;
    if ({err_chk, err_len, err_ovr, err_timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 0000", {err_chk, err_len, err_ovr, err_timeout});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h55); send_byte(8'h66);
    @(posedge clk); #1;
    rx_data = 8'h21;
    rx_done = 1'b1;
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", pkt_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got %b want 1", pkt_valid); end
    rx_done = 1'b0;
    n_cmp++;
    if (pkt_cmd !== 8'h10 || pkt_len !== 5'd2 || pkt_payload !== 64'h6655) begin
      n_bad++;
      $display("FAIL basic_pkt: got cmd=%h len=%0d pl=%h want 10/2/6655", pkt_cmd, pkt_len, pkt_payload);
    end
    accept();
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL basic_accept: got %b want 0", pkt_valid); end
  endtask

  task automatic test_len_zero();
    logic stable;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01 || pkt_len !== 5'd0 || pkt_payload !== 64'h0) begin
      n_bad++;
      $display("FAIL len0_pkt: got v=%b cmd=%h len=%0d pl=%h want 1/01/0/0",
               pkt_valid, pkt_cmd, pkt_len, pkt_payload);
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01 || pkt_len !== 5'd0 || pkt_payload !== 64'h0)
        stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_bad++; $display("FAIL len0_hold_stable: got %b want 1", stable); end
    accept();
  endtask

  task automatic test_bad_checksum();
    int base;
    base = n_err_chk;
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h22);
    n_cmp++;
    if (n_err_chk !== base + 1) begin n_bad++; $display("FAIL chk_pulse: got %0d want %0d", n_err_chk, base + 1); end
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL chk_no_valid: got %b want 0", pkt_valid); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01) begin
      n_bad++;
      $display("FAIL chk_recover: got v=%b cmd=%h want 1/01", pkt_valid, pkt_cmd);
    end
    accept();
  endtask

  task automatic test_len_err();
    int base;
    base = n_err_len;
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h09);
    n_cmp++;
    if (n_err_len !== base + 1) begin n_bad++; $display("FAIL len_err_pulse: got %0d want %0d", n_err_len, base + 1); end
    // Header held on rx_done for 20 cycles must count as a single byte.
    @(posedge clk); #1;
    rx_data = 8'hAA;
    rx_done = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01 || pkt_len !== 5'd0) begin
      n_bad++;
      $display("FAIL held_rx_done: got v=%b cmd=%h len=%0d want 1/01/0", pkt_valid, pkt_cmd, pkt_len);
    end
    accept();
  endtask

  task automatic test_max_len();
    // cmd 20, len 8, payload 01..08: csum = 20^08^(01^..^08) = 20^08^08 = 20
    send_byte(8'hAA); send_byte(8'h20); send_byte(8'h08);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h20);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_len !== 5'd8 || pkt_payload !== 64'h0807060504030201) begin
      n_bad++;
      $display("FAIL max_len: got v=%b len=%0d pl=%h want 1/8/0807060504030201",
               pkt_valid, pkt_len, pkt_payload);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    // Shorter packet after the full one: upper payload bytes must read 0.
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h21);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_payload !== 64'h6655) begin
      n_bad++;
      $display("FAIL b2b_clear: got v=%b pl=%h want 1/6655", pkt_valid, pkt_payload);
    end
    accept();
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h01); send_byte(8'hAA); send_byte(8'h98);
    // csum 33^01^AA = 98; header value inside payload is plain data
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h33 || pkt_len !== 5'd1 || pkt_payload !== 64'hAA) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b cmd=%h len=%0d pl=%h want 1/33/1/aa",
               pkt_valid, pkt_cmd, pkt_len, pkt_payload);
    end
    accept();
  endtask

  task automatic test_overrun();
    int base;
    int chk_base;
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h21);
    base = n_err_ovr;
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    n_cmp++;
    if (n_err_ovr !== base + 3) begin n_bad++; $display("FAIL ovr_count: got %0d want %0d", n_err_ovr, base + 3); end
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h10 || pkt_len !== 5'd2 || pkt_payload !== 64'h6655) begin
      n_bad++;
      $display("FAIL ovr_unchanged: got v=%b cmd=%h len=%0d pl=%h want 1/10/2/6655",
               pkt_valid, pkt_cmd, pkt_len, pkt_payload);
    end
    // Accept and a HEADER byte on the same edge: the byte is still dropped.
    chk_base = n_err_chk;
    @(posedge clk); #1;
    pkt_ready = 1'b1;
    rx_data   = 8'hAA;
    rx_done   = 1'b1;
    @(posedge clk); #1;
    pkt_ready = 1'b0;
    rx_done   = 1'b0;
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept: got %b want 0", pkt_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (n_err_ovr !== base + 4) begin n_bad++; $display("FAIL ovr_simul: got %0d want %0d", n_err_ovr, base + 4); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_cmp++;
    if (pkt_valid !== 1'b0 || n_err_chk !== chk_base) begin
      n_bad++;
      $display("FAIL ovr_dropped_hdr: got v=%b chk=%0d want 0/%0d", pkt_valid, n_err_chk, chk_base);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h55);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pkt_cmd !== 8'h00 || pkt_len !== 5'd0 || pkt_payload !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got cmd=%h len=%0d pl=%h want 0/0/0", pkt_cmd, pkt_len, pkt_payload);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_byte(8'h66); send_byte(8'h21);
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_discard: got %b want 0", pkt_valid); end
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h21);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_payload !== 64'h6655) begin
      n_bad++;
      $display("FAIL rst_mid_recover: got v=%b pl=%h want 1/6655", pkt_valid, pkt_payload);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_drop: got %b want 0", pkt_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef UART_PKT_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    base = n_err_to;
    send_byte(8'hAA); send_byte(8'h10);
    repeat (120) @(posedge clk);
    #1;
    n_cmp++;
    if (n_err_to !== base + 1) begin n_bad++; $display("FAIL timeout_pulse: got %0d want %0d", n_err_to, base + 1); end
    // Back in IDLE: the rest of the old frame is ignored.
    send_byte(8'h00); send_byte(8'h10);
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got %b want 0", pkt_valid); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01) begin
      n_bad++;
      $display("FAIL timeout_recover: got v=%b cmd=%h want 1/01", pkt_valid, pkt_cmd);
    end
    accept();
  endtask
`else
  task automatic test_no_timeout();
    send_byte(8'hAA); send_byte(8'h10);
    repeat (200) @(posedge clk);
    #1;
    send_byte(8'h00); send_byte(8'h10);
    n_cmp++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h10 || pkt_len !== 5'd0) begin
      n_bad++;
      $display("FAIL no_timeout_wait: got v=%b cmd=%h len=%0d want 1/10/0", pkt_valid, pkt_cmd, pkt_len);
    end
    n_cmp++;
    if (n_err_to !== 0) begin n_bad++; $display("FAIL no_timeout_pulse: got %0d want 0", n_err_to); end
    accept();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_bad_checksum();
    test_len_err();
    test_max_len();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_PKT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
